ntm_scalar_summation_sequencer: RTL and testbench

Sequencing controller for the NTM scalar adder datapath. It accepts a command giving an operand count and consumes that many scalars over a valid/ready stream. It accumulates them through a widened adder into a running sum and reports the final sum with a one-cycle done pulse. It sits between the NTM vector/matrix controllers and the scalar arithmetic layer, and turns the two-operand adder into an N-operand summation unit.

---
 rtl/ntm_scalar_summation_sequencer.sv | 127 ++++++++++++
 tb/tb_ntm_scalar_summation_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntm_scalar_summation_sequencer.sv
// ntm_scalar_summation_sequencer
//
// Turns the two-operand scalar adder into an N-operand summation unit.
// A command (start + length_in) arms the block; it then consumes length_in
// unsigned scalars over a valid/ready stream and accumulates them in a
// DATA_SIZE+CONTROL_SIZE wide register. The final sum appears on data_out
// together with a one-cycle ready pulse.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous reset, active low
//   start           command strobe, honoured only while idle
//   length_in       operand count, latched with an accepted start
//   clear           synchronous abort back to idle
//   data_in         operand (unsigned)
//   data_in_enable  operand valid
//   data_in_ready   operand accept, high while accumulating
//   data_out        final sum, held until reset or the next completed command
//   busy            high while accumulating or reporting
//   ready           one-cycle completion pulse
module ntm_scalar_summation_sequencer #(
  parameter int DATA_SIZE    = 8,
  parameter int CONTROL_SIZE = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [CONTROL_SIZE-1:0]           length_in,
  input  logic                              clear,
  input  logic [DATA_SIZE-1:0]              data_in,
  input  logic                              data_in_enable,
  output logic                              data_in_ready,
  output logic [DATA_SIZE+CONTROL_SIZE-1:0] data_out,
  output logic                              busy,
  output logic                              ready
);

  localparam int SW = DATA_SIZE + CONTROL_SIZE;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [SW-1:0]           acc_q, acc_d;
  logic [SW-1:0]           out_q, out_d;
  logic [CONTROL_SIZE-1:0] cnt_q, cnt_d;
  logic [CONTROL_SIZE-1:0] len_q, len_d;

  logic          hs;
  logic          last;
  logic [SW-1:0] sum;

  // Widened add: with at most 2^CONTROL_SIZE-1 operands the sum cannot
  // exceed SW bits, so no carry-out is kept.
  assign hs   = (state_q == S_ACC) && data_in_enable;
  assign sum  = acc_q + {{CONTROL_SIZE{1'b0}}, data_in};
  assign last = (cnt_q == (len_q - CONTROL_SIZE'(1)));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (clear) begin
      // Abort wins over start and over a handshake in the same cycle;
      // the operand in flight is dropped and data_out is left alone.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_d = '0;
            cnt_d = '0;
            len_d = length_in;
            if (length_in == '0) begin
              // Empty command reports a zero sum straight away.
              out_d   = '0;
              state_d = S_DONE;
            end else begin
              state_d = S_ACC;
            end
          end
        end
        S_ACC: begin
          if (hs) begin
            acc_d = sum;
            cnt_d = cnt_q + CONTROL_SIZE'(1);
            if (last) begin
              // Load the result including the final operand so it is
              // valid in the same cycle as the ready pulse.
              out_d   = sum;
              state_d = S_DONE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Status outputs decode the state register only, so they carry no
  // combinational path from any input.
  assign data_in_ready = (state_q == S_ACC);
  assign busy          = (state_q == S_ACC) || (state_q == S_DONE);
  assign ready         = (state_q == S_DONE);
  assign data_out      = out_q;

endmodule

// File: tb/tb_ntm_scalar_summation_sequencer.sv
module tb_ntm_scalar_summation_sequencer;

  localparam int DS = 8;
  localparam int CS = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [CS-1:0] length_in;
  logic          clear;
  logic [DS-1:0] data_in;
  logic          data_in_enable;
  logic          data_in_ready;
  logic [DS+CS-1:0] data_out;
  logic          busy;
  logic          ready;

  ntm_scalar_summation_sequencer #(.DATA_SIZE(DS), .CONTROL_SIZE(CS)) dut (
    .clk(clk), .rst(rst), .start(start), .length_in(length_in),
    .clear(clear), .data_in(data_in), .data_in_enable(data_in_enable),
    .data_in_ready(data_in_ready), .data_out(data_out), .busy(busy),
    .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: operands still owed, running total, pending pulse,
  // and the last reported sum.
  int m_rem   = 0;
  int m_sum   = 0;
  int m_out   = 0;
  bit m_pulse = 0;
  bit pulse_now;

  always @(posedge clk) begin
    if (!rst) begin
      m_rem = 0; m_sum = 0; m_out = 0; m_pulse = 0;
    end else begin
      pulse_now = m_pulse;
      m_pulse   = 0;
      if (clear) begin
        m_rem = 0;
      end else if (pulse_now) begin
        m_rem = 0;
      end else if (m_rem > 0) begin
        if (data_in_enable) begin
          m_sum = m_sum + int'(data_in);
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_pulse = 1;
            m_out   = m_sum;
          end
        end
      end else if (start) begin
        if (length_in == 0) begin
          m_pulse = 1;
          m_out   = 0;
        end else begin
          m_rem = int'(length_in);
          m_sum = 0;
        end
      end
    end
    #1;
    chk("ready",         32'(ready),         32'(m_pulse));
    chk("busy",          32'(busy),          32'(m_pulse || (m_rem > 0)));
    chk("data_in_ready", 32'(data_in_ready), 32'(m_rem > 0));
    chk("data_out",      32'(data_out),      32'(m_out));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_start(input int len);
    start = 1'b1; length_in = CS'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic send_op(input int v);
    data_in = DS'(v); data_in_enable = 1'b1;
    tick();
    data_in_enable = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      data_in = DS'($urandom); data_in_enable = 1'b0;
      tick();
    end
  endtask

  int len, ab, g;

  initial begin
    rst = 1'b0; start = 1'b0; length_in = '0; clear = 1'b0;
    data_in = '0; data_in_enable = 1'b0;
    #2;
    chk("reset data_in_ready", 32'(data_in_ready), 0);
    chk("reset busy",          32'(busy),          0);
    chk("reset ready",         32'(ready),         0);
    chk("reset data_out",      32'(data_out),      0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Basic: 3+5+7, ready 4 cycles after start
    send_start(3);
    chk("basic accepting", 32'(data_in_ready), 1);
    send_op(3); send_op(5);
    chk("basic no early ready", 32'(ready), 0);
    send_op(7);
    chk("basic ready", 32'(ready), 1);
    chk("basic sum", 32'(data_out), 15);
    chk("basic model sum", 32'(m_out), 15);
    tick();
    chk("basic ready one cycle", 32'(ready), 0);
    chk("basic busy drops", 32'(busy), 0);

    // Maximum length, no wrap
    send_start(15);
    repeat (15) send_op(255);
    chk("max ready", 32'(ready), 1);
    chk("max sum", 32'(data_out), 3825);
    chk("max model sum", 32'(m_out), 3825);
    tick();

    // Stalls between operands
    send_start(4);
    gap(0); send_op(1);
    gap(2); send_op(2);
    gap(5); send_op(3);
    gap(1);
    chk("stall no early ready", 32'(ready), 0);
    chk("stall old data_out held", 32'(data_out), 3825);
    send_op(4);
    chk("stall ready", 32'(ready), 1);
    chk("stall sum", 32'(data_out), 10);
    tick();

    // Length zero
    send_start(0);
    chk("len0 ready", 32'(ready), 1);
    chk("len0 sum", 32'(data_out), 0);
    tick();

    // Start while busy is ignored
    send_start(2);
    start = 1'b1; length_in = 4'd7;
    send_op(6);
    start = 1'b0;
    send_op(9);
    chk("ignored start ready", 32'(ready), 1);
    chk("ignored start sum", 32'(data_out), 15);
    tick();
    chk("ignored start not queued", 32'(busy), 0);

    // Abort after two handshakes
    send_start(5);
    send_op(4); send_op(4);
    clear = 1'b1; data_in = 8'd50; data_in_enable = 1'b1;
    tick();
    clear = 1'b0; data_in_enable = 1'b0;
    chk("abort idle", 32'(busy), 0);
    chk("abort no ready", 32'(ready), 0);
    chk("abort data_out held", 32'(data_out), 15);
    send_start(2);
    send_op(9); send_op(1);
    chk("after abort sum", 32'(data_out), 10);
    tick();

    // Asynchronous reset mid-operation
    send_start(5);
    send_op(3);
    #2 rst = 1'b0;
    #1;
    chk("async rst data_in_ready", 32'(data_in_ready), 0);
    chk("async rst busy",          32'(busy),          0);
    chk("async rst data_out",      32'(data_out),      0);
    tick();
    rst = 1'b1;
    tick();
    send_start(1);
    send_op(200);
    chk("post reset ready", 32'(ready), 1);
    chk("post reset sum", 32'(data_out), 200);
    tick();

    // Randomized commands: stalls, spurious starts, aborts, idle noise
    for (int c = 0; c < 60; c++) begin
      len = $urandom_range(0, 15);
      ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : -1;
      send_start(len);
      for (int k = 0; k < len; k++) begin
        g = $urandom_range(0, 3);
        repeat (g) begin
          data_in = DS'($urandom); data_in_enable = 1'b0;
          start = ($urandom_range(0, 5) == 0); length_in = CS'($urandom);
          tick();
        end
        start = 1'b0;
        if (k == ab) begin
          clear = 1'b1; data_in = DS'($urandom);
          data_in_enable = $urandom_range(0, 1) != 0;
          tick();
          clear = 1'b0; data_in_enable = 1'b0;
          break;
        end
        send_op($urandom_range(0, 255));
      end
      g = $urandom_range(1, 3);
      repeat (g) begin
        data_in = DS'($urandom); data_in_enable = $urandom_range(0, 1) != 0;
        clear = ($urandom_range(0, 7) == 0);
        tick();
      end
      clear = 1'b0; data_in_enable = 1'b0;
    end

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
